// File: rtl/calc1_pkg.sv
// calc1 scheduler shared definitions: command and response codes and the
// scheduler FSM state encoding.
package calc1_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'b00;
   localparam logic [1:0] RESP_OK   = 2'b01;
   localparam logic [1:0] RESP_ERR  = 2'b10;
   localparam logic [1:0] RESP_TMO  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_OP1,
      ST_SEND_OP2,
      ST_WAIT_RESP,
      ST_RESPOND,
      ST_REJECT
   } state_t;

endpackage

// File: rtl/calc1_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps.
//   req   : request vector
//   ptr   : highest-priority requester this cycle
//   grant : one-hot grant (all zero when no request)
//   idx   : index of the granted requester (0 when no request)
module calc1_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   int   cand;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && req[IDX_W'(cand)]) begin
            found                = 1'b1;
            grant[IDX_W'(cand)]  = 1'b1;
            idx                  = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/calc1_req_scheduler.sv
// Front-end scheduler for the calc1 core. Four requesters arbitrate
// round-robin; the winning operation is sent to the core as cmd+op1 then op2,
// and the core response (or a timeout) is returned to the originating requester.
//   c_clk, reset(active-low async)
//   req_valid/req_ready/req_cmd/req_op1/req_op2 : requester side
//   resp_valid/resp_code/resp_data               : response back to requesters
//   core_cmd_out/core_data_out/core_resp/core_data_in : calc1 core port
//   busy : FSM not idle;  stray_resp : sticky, core answered outside WAIT_RESP
//
// state        | meaning
// IDLE         | arbitrating, req_ready live
// SEND_OP1     | core sees cmd + op1
// SEND_OP2     | core sees op2, timeout timer loaded
// WAIT_RESP    | waiting for core_resp or timer terminal count
// RESPOND      | resp_valid strobe with core/timeout result
// REJECT       | resp_valid strobe with ERR for a no-op command
module calc1_req_scheduler import calc1_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int CMD_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                      c_clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [CMD_W*NUM_REQ-1:0]  req_cmd,
   input  logic [DATA_W*NUM_REQ-1:0] req_op1,
   input  logic [DATA_W*NUM_REQ-1:0] req_op2,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [1:0]                resp_code,
   output logic [DATA_W-1:0]         resp_data,
   output logic [CMD_W-1:0]          core_cmd_out,
   output logic [DATA_W-1:0]         core_data_out,
   input  logic [1:0]                core_resp,
   input  logic [DATA_W-1:0]         core_data_in,
   output logic                      busy,
   output logic                      stray_resp
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = $clog2(TIMEOUT);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   win_idx;
   logic [DATA_W-1:0]  cap_op2;
   logic [TMR_W-1:0]   tmr;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   arb_idx;
   logic [CMD_W-1:0]   cmd_sel;
   logic [DATA_W-1:0]  op1_sel;
   logic [DATA_W-1:0]  op2_sel;

   calc1_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (arb_idx)
   );

   always_comb begin
      cmd_sel = '0;
      op1_sel = '0;
      op2_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            cmd_sel = req_cmd[i*CMD_W +: CMD_W];
            op1_sel = req_op1[i*DATA_W +: DATA_W];
            op2_sel = req_op2[i*DATA_W +: DATA_W];
         end
      end
   end

   // Gated by reset so every output reads 0 while reset is held.
   assign req_ready = (state == ST_IDLE && reset) ? grant : '0;
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         win_idx       <= '0;
         cap_op2       <= '0;
         tmr           <= '0;
         resp_valid    <= '0;
         resp_code     <= RESP_NONE;
         resp_data     <= '0;
         core_cmd_out  <= '0;
         core_data_out <= '0;
         stray_resp    <= 1'b0;
      end else begin
         resp_valid <= '0;
         resp_code  <= RESP_NONE;
         resp_data  <= '0;

         // A response arriving when nobody is waiting is dropped, only flagged.
         if (core_resp != RESP_NONE && state != ST_WAIT_RESP)
            stray_resp <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  win_idx <= arb_idx;
                  cap_op2 <= op2_sel;
                  ptr     <= (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                  if (cmd_sel == CMD_W'(CMD_NOP)) begin
                     state      <= ST_REJECT;
                     resp_valid <= grant;
                     resp_code  <= RESP_ERR;
                  end else begin
                     state         <= ST_SEND_OP1;
                     core_cmd_out  <= cmd_sel;
                     core_data_out <= op1_sel;
                  end
               end
            end
            ST_SEND_OP1: begin
               state         <= ST_SEND_OP2;
               core_cmd_out  <= '0;
               core_data_out <= cap_op2;
            end
            ST_SEND_OP2: begin
               state         <= ST_WAIT_RESP;
               core_data_out <= '0;
               tmr           <= TMR_W'(TIMEOUT-1);
            end
            ST_WAIT_RESP: begin
               if (core_resp != RESP_NONE) begin
                  state      <= ST_RESPOND;
                  resp_valid <= NUM_REQ'(1) << win_idx;
                  resp_code  <= core_resp;
                  resp_data  <= core_data_in;
               end else if (tmr == '0) begin
                  state      <= ST_RESPOND;
                  resp_valid <= NUM_REQ'(1) << win_idx;
                  resp_code  <= RESP_TMO;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            ST_RESPOND: state <= ST_IDLE;
            ST_REJECT:  state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc1_req_scheduler.sv
module tb_calc1_req_scheduler;
   import calc1_pkg::*;

   logic        c_clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_cmd;
   logic [127:0] req_op1;
   logic [127:0] req_op2;
   logic [3:0]  resp_valid;
   logic [1:0]  resp_code;
   logic [31:0] resp_data;
   logic [3:0]  core_cmd_out;
   logic [31:0] core_data_out;
   logic [1:0]  core_resp;
   logic [31:0] core_data_in;
   logic        busy;
   logic        stray_resp;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 c_clk = ~c_clk;

   calc1_req_scheduler #(
      .NUM_REQ (4), .DATA_W (32), .CMD_W (4), .TIMEOUT (64)
   ) dut (
      .c_clk         (c_clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_cmd       (req_cmd),
      .req_op1       (req_op1),
      .req_op2       (req_op2),
      .resp_valid    (resp_valid),
      .resp_code     (resp_code),
      .resp_data     (resp_data),
      .core_cmd_out  (core_cmd_out),
      .core_data_out (core_data_out),
      .core_resp     (core_resp),
      .core_data_in  (core_data_in),
      .busy          (busy),
      .stray_resp    (stray_resp)
   );

   // core_lat: cycle after accept in which the core answers (0 = never)
   // exp_lat : cycle after accept in which resp_valid must strobe
   typedef struct {
      logic [3:0]  mask;
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [1:0]  core_code;
      logic [31:0] core_data;
      int          core_lat;
      int          win;
      logic [1:0]  exp_code;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t tbl[11];
   vec_t v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge c_clk);
      #1;
   endtask

   task automatic drive_reqs(input logic [3:0] mask, input logic [3:0] cmd,
                             input logic [31:0] op1, input logic [31:0] op2);
      req_valid = mask;
      for (int i = 0; i < 4; i++) begin
         req_cmd[i*4 +: 4]   = cmd;
         req_op1[i*32 +: 32] = op1;
         req_op2[i*32 +: 32] = op2;
      end
   endtask

   // Called in an IDLE cycle; returns in the IDLE cycle following the response.
   task automatic run_vec(input vec_t x, input int id);
      logic [3:0] oh;
      oh = 4'b0001 << x.win;
      drive_reqs(x.mask, x.cmd, x.op1, x.op2);
      #1;
      chk($sformatf("v%0d ready", id), {28'd0, req_ready}, {28'd0, oh});
      for (int c = 1; c <= x.exp_lat; c++) begin
         tick;
         if (x.core_lat != 0 && c == x.core_lat) begin
            core_resp    = x.core_code;
            core_data_in = x.core_data;
         end else begin
            core_resp    = RESP_NONE;
            core_data_in = 32'hDEAD_BEEF;
         end
         if (c == 1 && x.cmd != 4'd0) begin
            chk($sformatf("v%0d c%0d core_cmd", id, c), {28'd0, core_cmd_out}, {28'd0, x.cmd});
            chk($sformatf("v%0d c%0d core_data", id, c), core_data_out, x.op1);
         end else if (c == 2 && x.cmd != 4'd0) begin
            chk($sformatf("v%0d c%0d core_cmd", id, c), {28'd0, core_cmd_out}, 32'd0);
            chk($sformatf("v%0d c%0d core_data", id, c), core_data_out, x.op2);
         end else begin
            chk($sformatf("v%0d c%0d core_cmd", id, c), {28'd0, core_cmd_out}, 32'd0);
            chk($sformatf("v%0d c%0d core_data", id, c), core_data_out, 32'd0);
         end
         chk($sformatf("v%0d c%0d resp_valid", id, c), {28'd0, resp_valid},
             (c == x.exp_lat) ? {28'd0, oh} : 32'd0);
         if (c == x.exp_lat) begin
            chk($sformatf("v%0d resp_code", id), {30'd0, resp_code}, {30'd0, x.exp_code});
            chk($sformatf("v%0d resp_data", id), resp_data, x.exp_data);
         end
         chk($sformatf("v%0d c%0d busy", id, c), {31'd0, busy}, 32'd1);
         chk($sformatf("v%0d c%0d ready_busy", id, c), {28'd0, req_ready}, 32'd0);
         chk($sformatf("v%0d c%0d stray", id, c), {31'd0, stray_resp}, 32'd0);
      end
      tick;
      core_resp = RESP_NONE;
      chk($sformatf("v%0d idle busy", id), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d idle resp_valid", id), {28'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      //          mask     cmd      op1           op2         core  cdata          clat win ecode edata         elat
      tbl[0]  = '{4'b1111, CMD_SUB, 32'd10,       32'd4,      2'b01, 32'd6,         3, 0, 2'b01, 32'd6,         4};
      tbl[1]  = '{4'b1110, CMD_SUB, 32'd20,       32'd5,      2'b01, 32'd15,        3, 1, 2'b01, 32'd15,        4};
      tbl[2]  = '{4'b1100, CMD_SUB, 32'd30,       32'd6,      2'b01, 32'd24,        3, 2, 2'b01, 32'd24,        4};
      tbl[3]  = '{4'b1000, CMD_SUB, 32'd40,       32'd7,      2'b01, 32'd33,        3, 3, 2'b01, 32'd33,        4};
      tbl[4]  = '{4'b0001, CMD_ADD, 32'h5,        32'h3,      2'b01, 32'h8,         5, 0, 2'b01, 32'h8,         6};
      tbl[5]  = '{4'b0100, CMD_NOP, 32'h1234,     32'h5678,   2'b00, 32'h0,         0, 2, 2'b10, 32'h0,         1};
      tbl[6]  = '{4'b0010, 4'hF,    32'h1,        32'h2,      2'b10, 32'h0,         4, 1, 2'b10, 32'h0,         5};
      tbl[7]  = '{4'b0011, CMD_SHL, 32'h1,        32'h4,      2'b01, 32'h10,        3, 0, 2'b01, 32'h10,        4};
      tbl[8]  = '{4'b0011, CMD_SHR, 32'h80,       32'h3,      2'b01, 32'h10,        3, 1, 2'b01, 32'h10,        4};
      tbl[9]  = '{4'b1101, CMD_SUB, 32'h0,        32'h1,      2'b10, 32'h0,         6, 2, 2'b10, 32'h0,         7};
      tbl[10] = '{4'b0101, CMD_ADD, 32'hFFFF_FFFE,32'h1,      2'b01, 32'hFFFF_FFFF, 3, 0, 2'b01, 32'hFFFF_FFFF, 4};

      reset        = 1'b0;
      core_resp    = RESP_NONE;
      core_data_in = '0;
      drive_reqs(4'b1000, CMD_ADD, 32'h1, 32'h1);
      #1;
      chk("rst ready", {28'd0, req_ready}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      tick;
      tick;
      chk("rst resp_valid", {28'd0, resp_valid}, 32'd0);
      chk("rst resp_code", {30'd0, resp_code}, 32'd0);
      chk("rst core_cmd", {28'd0, core_cmd_out}, 32'd0);
      chk("rst stray", {31'd0, stray_resp}, 32'd0);
      req_valid = 4'b0000;
      reset     = 1'b1;
      tick;
      chk("post-rst busy", {31'd0, busy}, 32'd0);

      for (int k = 0; k < 11; k++) run_vec(tbl[k], k);
      req_valid = 4'b0000;

      // Arbitration is re-evaluated while idle; valid may drop without ready (ptr = 1).
      req_valid = 4'b0100; #1;
      chk("reeval a", {28'd0, req_ready}, 32'b0100);
      req_valid = 4'b0010; #1;
      chk("reeval b", {28'd0, req_ready}, 32'b0010);
      req_valid = 4'b0000; #1;
      chk("reeval c", {28'd0, req_ready}, 32'd0);

      // Timeout: ptr = 1, core silent; response at T+3+64 = T+67.
      v = '{4'b0010, CMD_ADD, 32'h9, 32'h9, 2'b00, 32'h0, 0, 1, 2'b11, 32'h0, 67};
      run_vec(v, 100);
      req_valid = 4'b0000;
      // now at T+68; late core answer at T+70
      tick;
      chk("late c69 resp_valid", {28'd0, resp_valid}, 32'd0);
      tick;
      core_resp    = RESP_OK;
      core_data_in = 32'h55;
      chk("late c70 stray", {31'd0, stray_resp}, 32'd0);
      tick;
      core_resp = RESP_NONE;
      chk("late c71 stray", {31'd0, stray_resp}, 32'd1);
      chk("late c71 resp_valid", {28'd0, resp_valid}, 32'd0);
      tick;
      chk("late c72 resp_valid", {28'd0, resp_valid}, 32'd0);
      chk("late c72 busy", {31'd0, busy}, 32'd0);
      chk("late c72 stray", {31'd0, stray_resp}, 32'd1);

      // Reset mid-operation: requester 2 accepted (ptr 2 -> 3), reset in WAIT_RESP.
      drive_reqs(4'b0100, CMD_ADD, 32'h3, 32'h4);
      #1;
      chk("mid ready", {28'd0, req_ready}, 32'b0100);
      tick;
      req_valid = 4'b1000;
      for (int c = 2; c <= 10; c++) tick;
      chk("mid busy before rst", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid rst busy", {31'd0, busy}, 32'd0);
      chk("mid rst ready", {28'd0, req_ready}, 32'd0);
      chk("mid rst resp_valid", {28'd0, resp_valid}, 32'd0);
      chk("mid rst stray", {31'd0, stray_resp}, 32'd0);
      tick;
      chk("mid rst hold resp_valid", {28'd0, resp_valid}, 32'd0);
      reset     = 1'b1;
      req_valid = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         tick;
         chk($sformatf("after rst c%0d resp_valid", c), {28'd0, resp_valid}, 32'd0);
      end
      // Pointer back at 0: requesters 0 and 3 both valid, 0 must win.
      v = '{4'b1001, CMD_ADD, 32'h7, 32'h8, 2'b01, 32'hF, 3, 0, 2'b01, 32'hF, 4};
      run_vec(v, 101);
      v = '{4'b1000, CMD_SUB, 32'h9, 32'h4, 2'b01, 32'h5, 3, 3, 2'b01, 32'h5, 4};
      run_vec(v, 102);
      req_valid = 4'b0000;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
